// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game controller.
package snake_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PLAY  = 2'b01,
      ST_DYING = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   localparam int TICK_W        = 26;
   localparam int FLASH_TOGGLES = 8;

   // Opposite heading; a snake may never turn straight back into itself.
   function automatic dir_t reverse_dir(input dir_t d);
      case (d)
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         DIR_LEFT:  return DIR_RIGHT;
         default:   return DIR_LEFT;
      endcase
   endfunction

   // Four-digit BCD increment that sticks at 9999.
   function automatic logic [15:0] bcd_inc_sat(input logic [15:0] s);
      logic [15:0] r;
      logic        carry;
      r     = s;
      carry = 1'b1;
      if (s != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-count debouncer,
// and a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic ClkPort,
   input  logic Reset,
   input  logic btn,
   output logic press
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic          level;
   logic [CW-1:0] cnt;

   // Bring the raw button into the clock domain.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= btn;
         sync <= meta;
      end
   end

   // Accept a new level only after it has held for the full window; pulse on acceptance of a press.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else if (sync != level) begin
         if (cnt == CNT_LAST) begin
            level <= sync;
            cnt   <= '0;
            press <= sync;
         end else begin
            cnt   <= cnt + CW'(1);
            press <= 1'b0;
         end
      end else begin
         cnt   <= '0;
         press <= 1'b0;
      end
   end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control: button conditioning, game-state FSM, move timing,
// direction commit, BCD score, speed levels and the death flash.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a first press; it sets the starting heading
//   ST_PLAY  | tick counter runs, turns queue, food scores, collision ends
//   ST_DYING | snake flashes via blank_o, input ignored
//   ST_OVER  | score/level frozen; a press clears them and returns to IDLE
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int BASE_PERIOD     = 4_194_304,
   parameter int MIN_PERIOD      = 524_288,
   parameter int SPEED_STEP      = 262_144,
   parameter int FOODS_PER_LEVEL = 5
) (
   input  logic        ClkPort,
   input  logic        Reset,
   input  logic        BtnU,
   input  logic        BtnD,
   input  logic        BtnL,
   input  logic        BtnR,
   input  logic        collision_i,
   input  logic        food_eaten_i,
   output logic        move_tick_o,
   output logic [1:0]  dir_o,
   output logic [1:0]  state_o,
   output logic [15:0] score_bcd_o,
   output logic [3:0]  level_o,
   output logic        blank_o
);

   localparam int                FW         = $clog2(FOODS_PER_LEVEL + 1);
   localparam logic [FW-1:0]     FOOD_LAST  = FW'(FOODS_PER_LEVEL - 1);
   localparam int                FLASH      = (BASE_PERIOD / 4 > 0) ? BASE_PERIOD / 4 : 1;
   localparam logic [TICK_W-1:0] FLASH_LOAD = TICK_W'(FLASH - 1);
   localparam logic [TICK_W-1:0] BASE_P     = TICK_W'(BASE_PERIOD);
   localparam logic [TICK_W-1:0] MIN_P      = TICK_W'(MIN_PERIOD);
   localparam logic [TICK_W-1:0] STEP_P     = TICK_W'(SPEED_STEP);
   localparam logic [TICK_W-1:0] LVL_FLOOR  = TICK_W'(MIN_PERIOD + SPEED_STEP);
   localparam logic [2:0]        LAST_TGL   = 3'(FLASH_TOGGLES - 1);

   logic press_u, press_d, press_l, press_r;
   logic press_any;
   dir_t press_dir;
   logic turn_ok;

   state_t            state;
   dir_t              dir;
   dir_t              pending;
   logic [TICK_W-1:0] period;
   logic [TICK_W-1:0] tick_cnt;
   logic [TICK_W-1:0] flash_cnt;
   logic [2:0]        flash_tgl;
   logic [FW-1:0]     food_cnt;
   logic [15:0]       score;
   logic [3:0]        level;
   logic              move_tick;
   logic              blank;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (
      .ClkPort(ClkPort), .Reset(Reset), .btn(BtnU), .press(press_u));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
      .ClkPort(ClkPort), .Reset(Reset), .btn(BtnD), .press(press_d));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
      .ClkPort(ClkPort), .Reset(Reset), .btn(BtnL), .press(press_l));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
      .ClkPort(ClkPort), .Reset(Reset), .btn(BtnR), .press(press_r));

   // Pick the winning press (U > D > L > R) and decide if it is a legal turn.
   // A turn that reverses either the committed heading or the already-queued
   // one is dropped, so a quick U-then-D from a rightward heading keeps U.
   always_comb begin
      press_any = press_u | press_d | press_l | press_r;
      if (press_u)      press_dir = DIR_UP;
      else if (press_d) press_dir = DIR_DOWN;
      else if (press_l) press_dir = DIR_LEFT;
      else              press_dir = DIR_RIGHT;
      turn_ok = press_any && (press_dir != reverse_dir(dir))
                          && (press_dir != reverse_dir(pending));
   end

   // Game FSM with all outputs registered.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         state     <= ST_IDLE;
         dir       <= DIR_RIGHT;
         pending   <= DIR_RIGHT;
         period    <= BASE_P;
         tick_cnt  <= '0;
         flash_cnt <= '0;
         flash_tgl <= '0;
         food_cnt  <= '0;
         score     <= '0;
         level     <= '0;
         move_tick <= 1'b0;
         blank     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               move_tick <= 1'b0;
               blank     <= 1'b0;
               if (press_any) begin
                  state    <= ST_PLAY;
                  dir      <= press_dir;
                  pending  <= press_dir;
                  tick_cnt <= '0;
                  period   <= BASE_P;
               end
            end
            ST_PLAY: begin
               if (food_eaten_i) begin
                  score <= bcd_inc_sat(score);
                  if (food_cnt == FOOD_LAST) begin
                     food_cnt <= '0;
                     if (level != 4'hF) level <= level + 4'd1;
                     period <= (period >= LVL_FLOOR) ? period - STEP_P : MIN_P;
                  end else begin
                     food_cnt <= food_cnt + FW'(1);
                  end
               end
               if (collision_i) begin
                  state     <= ST_DYING;
                  move_tick <= 1'b0;
                  flash_cnt <= FLASH_LOAD;
                  flash_tgl <= '0;
                  blank     <= 1'b0;
               end else begin
                  if (turn_ok) pending <= press_dir;
                  // >= so a shortened period catches a counter already past it
                  if (tick_cnt >= period - TICK_W'(1)) begin
                     move_tick <= 1'b1;
                     tick_cnt  <= '0;
                     dir       <= pending;
                  end else begin
                     move_tick <= 1'b0;
                     tick_cnt  <= tick_cnt + TICK_W'(1);
                  end
               end
            end
            ST_DYING: begin
               move_tick <= 1'b0;
               if (flash_cnt == '0) begin
                  flash_cnt <= FLASH_LOAD;
                  flash_tgl <= flash_tgl + 3'd1;
                  if (flash_tgl == LAST_TGL) begin
                     state <= ST_OVER;
                     blank <= 1'b0;
                  end else begin
                     blank <= ~blank;
                  end
               end else begin
                  flash_cnt <= flash_cnt - TICK_W'(1);
               end
            end
            default: begin
               move_tick <= 1'b0;
               blank     <= 1'b0;
               if (press_any) begin
                  state    <= ST_IDLE;
                  score    <= '0;
                  level    <= '0;
                  food_cnt <= '0;
                  tick_cnt <= '0;
               end
            end
         endcase
      end
   end

   assign move_tick_o = move_tick;
   assign dir_o       = dir;
   assign state_o     = state;
   assign score_bcd_o = score;
   assign level_o     = level;
   assign blank_o     = blank;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl with small timing parameters.
module tb_snake_game_ctrl;

   localparam int DEB  = 4;
   localparam int BASE = 16;
   localparam int MINP = 8;
   localparam int STEP = 4;
   localparam int FPL  = 2;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic bu   = 1'b0;
   logic bd   = 1'b0;
   logic bl   = 1'b0;
   logic br   = 1'b0;
   logic coll = 1'b0;
   logic food = 1'b0;

   logic        move_tick;
   logic [1:0]  dir;
   logic [1:0]  st;
   logic [15:0] score;
   logic [3:0]  level;
   logic        blank;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   snake_game_ctrl #(
      .DEBOUNCE_CYCLES(DEB), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP),
      .SPEED_STEP(STEP), .FOODS_PER_LEVEL(FPL)
   ) dut (
      .ClkPort(clk), .Reset(rst),
      .BtnU(bu), .BtnD(bd), .BtnL(bl), .BtnR(br),
      .collision_i(coll), .food_eaten_i(food),
      .move_tick_o(move_tick), .dir_o(dir), .state_o(st),
      .score_bcd_o(score), .level_o(level), .blank_o(blank)
   );

   // ---------------- reference model (game rules, plain arithmetic) -------
   function automatic logic [15:0] to_bcd(input int n);
      int v;
      v = (n > 9999) ? 9999 : n;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int exp_level(input int foods);
      int l;
      l = foods / FPL;
      return (l > 15) ? 15 : l;
   endfunction

   function automatic int exp_period(input int foods);
      int p;
      p = BASE - STEP * (foods / FPL);
      return (p < MINP) ? MINP : p;
   endfunction

   // ---------------- stimulus helpers ------------------------------------
   task step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task set_btn(input int b, input logic v);
      case (b)
         0: bu = v;
         1: bd = v;
         2: bl = v;
         default: br = v;
      endcase
   endtask

   task wait_state(input logic [1:0] s, input int budget, output bit ok);
      int n;
      n = 0;
      while (st !== s && n < budget) begin step(); n++; end
      ok = (st === s);
   endtask

   task wait_tick(input int budget, output bit ok);
      int n;
      n = 0;
      do begin step(); n++; end while (move_tick !== 1'b1 && n < budget);
      ok = (move_tick === 1'b1);
   endtask

   task measure_interval(input int budget, output int n);
      n = 0;
      do begin step(); n++; end while (move_tick !== 1'b1 && n < budget);
      if (move_tick !== 1'b1) n = -1;
   endtask

   task do_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task start_game(input int b, output bit ok);
      set_btn(b, 1'b1);
      repeat (8) step();
      set_btn(b, 1'b0);
      wait_state(2'b01, 10, ok);
      repeat (8) step();
   endtask

   // ---------------- scenarios -------------------------------------------
   task test_reset();
      bit idle_ok;
      rst = 1'b1;
      step(); step();
      n_checks++; if (st !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", st); end
      n_checks++; if (dir !== 2'b11) begin n_fail++; $display("FAIL reset_dir: got %b expected 11", dir); end
      n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL reset_score: got %h expected 0000", score); end
      n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
      n_checks++; if (move_tick !== 1'b0 || blank !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got tick=%b blank=%b expected 0/0", move_tick, blank); end
      rst = 1'b0;
      idle_ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
         coll = (i == 5);
         food = (i == 9);
         step();
         if (move_tick !== 1'b0 || st !== 2'b00 || score !== 16'h0000) idle_ok = 1'b0;
      end
      coll = 1'b0; food = 1'b0;
      n_checks++; if (!idle_ok) begin n_fail++; $display("FAIL idle_quiet: got state=%b score=%h expected 00/0000 without ticks", st, score); end
   endtask

   task test_debounce();
      bit ok;
      bl = 1'b1;
      repeat (3) step();
      bl = 1'b0;
      repeat (12) step();
      n_checks++; if (st !== 2'b00) begin n_fail++; $display("FAIL short_press: got state %b expected 00", st); end
      bl = 1'b1;
      repeat (10) step();
      bl = 1'b0;
      wait_state(2'b01, 4, ok);
      repeat (8) step();
      n_checks++; if (st !== 2'b01) begin n_fail++; $display("FAIL long_press_state: got %b expected 01", st); end
      n_checks++; if (dir !== 2'b10) begin n_fail++; $display("FAIL long_press_dir: got %b expected 10", dir); end
   endtask

   task test_ticks_levels();
      bit ok;
      int n;
      wait_tick(40, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL first_tick: got none expected a tick within 40 cycles"); end
      for (int i = 0; i < 3; i++) begin
         measure_interval(40, n);
         n_checks++; if (n != exp_period(0)) begin n_fail++; $display("FAIL base_interval: got %0d expected %0d", n, exp_period(0)); end
      end
      food = 1'b1; repeat (4) step(); food = 1'b0;
      n_checks++; if (level !== 4'(exp_level(4)) || score !== to_bcd(4)) begin n_fail++; $display("FAIL four_foods: got level=%0d score=%h expected %0d/%h", level, score, exp_level(4), to_bcd(4)); end
      wait_tick(40, ok);
      for (int i = 0; i < 2; i++) begin
         measure_interval(40, n);
         n_checks++; if (n != exp_period(4)) begin n_fail++; $display("FAIL level2_interval: got %0d expected %0d", n, exp_period(4)); end
      end
      food = 1'b1; repeat (2) step(); food = 1'b0;
      n_checks++; if (level !== 4'(exp_level(6))) begin n_fail++; $display("FAIL six_foods_level: got %0d expected %0d", level, exp_level(6)); end
      wait_tick(40, ok);
      measure_interval(40, n);
      n_checks++; if (n != exp_period(6)) begin n_fail++; $display("FAIL min_interval: got %0d expected %0d", n, exp_period(6)); end
      n_checks++; if (dir !== 2'b10) begin n_fail++; $display("FAIL dir_hold: got %b expected 10", dir); end
   endtask

   task test_direction();
      bit ok;
      do_reset();
      start_game(3, ok);
      n_checks++; if (!ok || dir !== 2'b11) begin n_fail++; $display("FAIL start_right: got state=%b dir=%b expected 01/11", st, dir); end
      wait_tick(40, ok);
      bu = 1'b1; step();
      bd = 1'b1; repeat (8) step();
      n_checks++; if (dir !== 2'b11) begin n_fail++; $display("FAIL dir_before_tick: got %b expected 11", dir); end
      bu = 1'b0; bd = 1'b0;
      wait_tick(20, ok);
      n_checks++; if (!ok || dir !== 2'b00) begin n_fail++; $display("FAIL u_then_d: got %b expected 00", dir); end
      repeat (8) step();
      bd = 1'b1; repeat (8) step(); bd = 1'b0; repeat (8) step();
      wait_tick(40, ok); wait_tick(40, ok);
      n_checks++; if (dir !== 2'b00) begin n_fail++; $display("FAIL reverse_ignored: got %b expected 00", dir); end
      bl = 1'b1; repeat (8) step(); bl = 1'b0; repeat (8) step();
      wait_tick(40, ok); wait_tick(40, ok);
      n_checks++; if (dir !== 2'b10) begin n_fail++; $display("FAIL turn_left: got %b expected 10", dir); end
   endtask

   task test_collision();
      bit ok;
      int toggles, bad_gap, ticks, last_t, k;
      logic prev;
      do_reset();
      start_game(0, ok);
      food = 1'b1; repeat (9) step(); food = 1'b0;
      n_checks++; if (score !== to_bcd(9)) begin n_fail++; $display("FAIL score9: got %h expected %h", score, to_bcd(9)); end
      wait_tick(40, ok);
      repeat (exp_period(9) - 1) step();
      coll = 1'b1; food = 1'b1;
      step();
      coll = 1'b0; food = 1'b0;
      n_checks++; if (move_tick !== 1'b0) begin n_fail++; $display("FAIL collide_tick: got %b expected 0", move_tick); end
      n_checks++; if (st !== 2'b10) begin n_fail++; $display("FAIL collide_state: got %b expected 10", st); end
      n_checks++; if (score !== to_bcd(10)) begin n_fail++; $display("FAIL collide_score: got %h expected %h", score, to_bcd(10)); end
      toggles = 0; bad_gap = 0; ticks = 0; last_t = cyc; prev = blank; k = 0;
      while (k < 100) begin
         br = (k >= 2 && k < 10);
         step(); k++;
         if (move_tick !== 1'b0) ticks++;
         if (blank !== prev) begin
            toggles++;
            if (cyc - last_t != BASE / 4) bad_gap++;
            last_t = cyc;
         end
         prev = blank;
         if (st !== 2'b10) break;
      end
      br = 1'b0;
      n_checks++; if (toggles != 8 || bad_gap != 0) begin n_fail++; $display("FAIL flash: got %0d toggles %0d bad gaps expected 8/0", toggles, bad_gap); end
      n_checks++; if (st !== 2'b11 || blank !== 1'b0) begin n_fail++; $display("FAIL over_entry: got state=%b blank=%b expected 11/0", st, blank); end
      n_checks++; if (ticks != 0) begin n_fail++; $display("FAIL dying_ticks: got %0d expected 0", ticks); end
      food = 1'b1; step(); food = 1'b0;
      repeat (20) step();
      n_checks++; if (st !== 2'b11 || score !== to_bcd(10) || level !== 4'(exp_level(10))) begin n_fail++; $display("FAIL over_hold: got state=%b score=%h level=%0d expected 11/%h/%0d", st, score, level, to_bcd(10), exp_level(10)); end
   endtask

   task test_saturate_over();
      bit ok, stayed;
      int k;
      do_reset();
      start_game(1, ok);
      k = $urandom_range(100, 999);
      food = 1'b1; repeat (k) step(); food = 1'b0;
      n_checks++; if (score !== to_bcd(k)) begin n_fail++; $display("FAIL partial_score: got %h expected %h", score, to_bcd(k)); end
      food = 1'b1; repeat (9999 - k + 5) step(); food = 1'b0;
      n_checks++; if (score !== 16'h9999 || level !== 4'd15) begin n_fail++; $display("FAIL saturate: got score=%h level=%0d expected 9999/15", score, level); end
      coll = 1'b1; step(); coll = 1'b0;
      wait_state(2'b11, 60, ok);
      n_checks++; if (!ok || score !== 16'h9999 || level !== 4'd15) begin n_fail++; $display("FAIL over_frozen: got state=%b score=%h level=%0d expected 11/9999/15", st, score, level); end
      bd = 1'b1;
      wait_state(2'b00, 15, ok);
      n_checks++; if (!ok || score !== 16'h0000 || level !== 4'd0) begin n_fail++; $display("FAIL over_press: got state=%b score=%h level=%0d expected 00/0000/0", st, score, level); end
      stayed = 1'b1;
      repeat (20) begin step(); if (st !== 2'b00) stayed = 1'b0; end
      bd = 1'b0;
      repeat (10) step();
      n_checks++; if (!stayed || st !== 2'b00) begin n_fail++; $display("FAIL held_single_press: got state %b expected 00", st); end
   endtask

   task test_random_play();
      bit ok;
      int b, foods, n;
      do_reset();
      b = $urandom_range(0, 3);
      start_game(b, ok);
      n_checks++; if (!ok || dir !== 2'(b)) begin n_fail++; $display("FAIL rand_start: got state=%b dir=%b expected 01/%0d", st, dir, b); end
      foods = 0;
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 20)) step();
         food = 1'b1; step(); food = 1'b0;
         foods++;
         n_checks++; if (score !== to_bcd(foods) || level !== 4'(exp_level(foods))) begin n_fail++; $display("FAIL rand_food: got score=%h level=%0d expected %h/%0d", score, level, to_bcd(foods), exp_level(foods)); end
      end
      wait_tick(40, ok);
      measure_interval(40, n);
      n_checks++; if (n != exp_period(foods)) begin n_fail++; $display("FAIL rand_interval: got %0d expected %0d", n, exp_period(foods)); end
   endtask

   task test_reset_mid_play();
      bit ok;
      int ticks;
      do_reset();
      start_game(2, ok);
      food = 1'b1; step(); food = 1'b0;
      wait_tick(40, ok);
      repeat (5) step();
      #2 rst = 1'b1;
      #1;
      n_checks++; if (st !== 2'b00 || dir !== 2'b11 || move_tick !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctl: got state=%b dir=%b tick=%b expected 00/11/0", st, dir, move_tick); end
      n_checks++; if (score !== 16'h0000 || level !== 4'd0 || blank !== 1'b0) begin n_fail++; $display("FAIL async_reset_data: got score=%h level=%0d blank=%b expected 0000/0/0", score, level, blank); end
      ticks = 0;
      repeat (20) begin step(); if (move_tick !== 1'b0) ticks++; end
      rst = 1'b0;
      repeat (40) begin step(); if (move_tick !== 1'b0) ticks++; end
      n_checks++; if (ticks != 0 || st !== 2'b00) begin n_fail++; $display("FAIL post_reset_quiet: got %0d ticks state=%b expected 0/00", ticks, st); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_ticks_levels();
      test_direction();
      test_collision();
      test_saturate_over();
      test_random_play();
      test_reset_mid_play();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
